// File: rtl/shift_mix_columns.sv
// AES round stage after SubBytes: ShiftRows on capture, then MixColumns over
// N = 4/COLS_PER_CYCLE cycles (bypassed on the final round), start/busy/done handshake.
module shift_mix_columns #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         last_round,
  input  logic [127:0] state_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out
);

  localparam int unsigned STATE_W  = 128;
  localparam int unsigned COL_W    = 32;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned N        = NUM_COLS / COLS_PER_CYCLE;
  localparam int unsigned CNT_W    = 2;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("shift_mix_columns: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; a0 is the most significant byte (row 0).
  function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    mix_col = {b0, b1, b2, b3};
  endfunction

  // Row r rotates left by r columns: s'[r][c] = s[r][(c+r)%4].
  function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    shift_rows = o;
  endfunction

  state_e             st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [STATE_W-1:0] state_out_q, state_out_d;
  logic [STATE_W-1:0] work_mixed;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      state_out_q <= '0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      state_out_q <= state_out_d;
    end
  end

  // Columns owned by the current count are mixed in place; the rest pass through.
  always_comb begin
    work_mixed = work_q;
    for (int c = 0; c < 4; c++) begin
      if (CNT_W'(c / COLS_PER_CYCLE) == cnt_q && !last_q) begin
        work_mixed[127-32*c -: 32] = mix_col(work_q[127-32*c -: 32]);
      end
    end
  end

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    last_d      = last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    state_out_d = state_out_q;
    case (st_q)
      IDLE: begin
        if (start) begin
          work_d = shift_rows(state_in);
          last_d = last_round;
          cnt_d  = '0;
          busy_d = 1'b1;
          st_d   = RUN;
        end
      end
      RUN: begin
        work_d = work_mixed;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          st_d        = IDLE;
          cnt_d       = '0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_out_d = work_mixed;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = state_out_q;

endmodule

// File: tb/tb_shift_mix_columns.sv
// Directed bench for shift_mix_columns: FIPS-197 round vectors, abort/ignore/back-to-back
// handshake cases, and the 2- and 4-column-per-cycle variants.
module tb_shift_mix_columns;

  localparam logic [127:0] C1 = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] E1 = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] E2 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] C3 = {4{32'hdb135345}};
  localparam logic [127:0] E3 = {4{32'h8e4da1bc}};
  localparam int MAX_WAIT = 12;

  logic         clk;
  logic         rst;
  logic         start1, start2, start4;
  logic         last_round;
  logic [127:0] state_in;
  logic         busy1, busy2, busy4;
  logic         done1, done2, done4;
  logic [127:0] out1, out2, out4;

  int checks;
  int failures;

  shift_mix_columns #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .last_round(last_round), .state_in(state_in),
    .busy(busy1), .done(done1), .state_out(out1));
  shift_mix_columns #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .last_round(last_round), .state_in(state_in),
    .busy(busy2), .done(done2), .state_out(out2));
  shift_mix_columns #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .last_round(last_round), .state_in(state_in),
    .busy(busy4), .done(done4), .state_out(out4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cur_done(input int which);
    case (which)
      2:       cur_done = done2;
      4:       cur_done = done4;
      default: cur_done = done1;
    endcase
  endfunction

  function automatic logic [127:0] cur_out(input int which);
    case (which)
      2:       cur_out = out2;
      4:       cur_out = out4;
      default: cur_out = out1;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start on one instance, then counts edges until done (bounded).
  task automatic run_op(input int which, input logic [127:0] din, input logic lr,
                        output int lat, output logic [127:0] res);
    state_in   = din;
    last_round = lr;
    start1     = (which == 1);
    start2     = (which == 2);
    start4     = (which == 4);
    step();
    start1 = 1'b0;
    start2 = 1'b0;
    start4 = 1'b0;
    lat    = 0;
    while (!cur_done(which) && lat < MAX_WAIT) begin
      step();
      lat++;
    end
    res = cur_out(which);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0 || busy4 !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b%b%b expected 000", busy1, busy2, busy4); end
    checks++; if (done1 !== 1'b0 || done2 !== 1'b0 || done4 !== 1'b0) begin
      failures++; $display("FAIL reset_done: got %b%b%b expected 000", done1, done2, done4); end
    checks++; if (out1 !== 128'h0) begin
      failures++; $display("FAIL reset_out1: got %h expected 0", out1); end
    checks++; if (out2 !== 128'h0 || out4 !== 128'h0) begin
      failures++; $display("FAIL reset_out24: got %h/%h expected 0", out2, out4); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_mix_round();
    int lat;
    logic [127:0] res;
    state_in = C1; last_round = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    checks++; if (busy1 !== 1'b1) begin
      failures++; $display("FAIL round_busy: got %b expected 1", busy1); end
    lat = 0;
    while (!done1 && lat < MAX_WAIT) begin step(); lat++; end
    res = out1;
    checks++; if (lat != 4) begin
      failures++; $display("FAIL round_latency: got %0d expected 4", lat); end
    checks++; if (res !== E1) begin
      failures++; $display("FAIL round_result: got %h expected %h", res, E1); end
    checks++; if (busy1 !== 1'b0) begin
      failures++; $display("FAIL round_busy_done: got %b expected 0", busy1); end
    step();
    checks++; if (done1 !== 1'b0) begin
      failures++; $display("FAIL round_done_width: got %b expected 0", done1); end
    checks++; if (out1 !== E1) begin
      failures++; $display("FAIL round_hold: got %h expected %h", out1, E1); end
  endtask

  task automatic test_last_round();
    int lat;
    logic [127:0] res;
    run_op(1, C1, 1'b1, lat, res);
    checks++; if (lat != 4) begin
      failures++; $display("FAIL last_latency: got %0d expected 4", lat); end
    checks++; if (res !== E2) begin
      failures++; $display("FAIL last_result: got %h expected %h", res, E2); end
    step();
  endtask

  task automatic test_invariant();
    int lat;
    logic [127:0] res;
    run_op(1, C3, 1'b0, lat, res);
    checks++; if (res !== E3) begin
      failures++; $display("FAIL invariant_col: got %h expected %h", res, E3); end
    step();
    run_op(1, 128'h0, 1'b0, lat, res);
    checks++; if (res !== 128'h0 || lat != 4) begin
      failures++; $display("FAIL all_zero: got %h lat %0d expected 0 lat 4", res, lat); end
    step();
  endtask

  task automatic test_start_while_busy();
    int pulses;
    int at;
    logic [127:0] res;
    pulses = 0; at = -1; res = '0;
    state_in = C1; last_round = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    state_in = C3; last_round = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int i = 3; i < 12; i++) begin
      step();
      if (done1) begin pulses++; at = i; res = out1; end
    end
    checks++; if (pulses != 1 || at != 4) begin
      failures++; $display("FAIL ignore_done: got pulses=%0d at=%0d expected 1 at 4", pulses, at); end
    checks++; if (res !== E1) begin
      failures++; $display("FAIL ignore_result: got %h expected %h", res, E1); end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    int lat;
    logic [127:0] res;
    state_in = C3; last_round = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      failures++; $display("FAIL abort_flags: got busy=%b done=%b expected 0 0", busy1, done1); end
    checks++; if (out1 !== 128'h0) begin
      failures++; $display("FAIL abort_out: got %h expected 0", out1); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done1) pulses++;
    end
    checks++; if (pulses != 0) begin
      failures++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); end
    run_op(1, C1, 1'b0, lat, res);
    checks++; if (lat != 4 || res !== E1) begin
      failures++; $display("FAIL abort_recover: got %h lat %0d expected %h lat 4", res, lat, E1); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [127:0] res;
    run_op(1, C1, 1'b0, lat, res);
    state_in = C1; last_round = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b1) begin
      failures++; $display("FAIL b2b_accept: got done=%b busy=%b expected 0 1", done1, busy1); end
    checks++; if (out1 !== E1) begin
      failures++; $display("FAIL b2b_hold: got %h expected %h", out1, E1); end
    lat = 0;
    while (!done1 && lat < MAX_WAIT) begin
      step();
      lat++;
      if (!done1 && out1 !== E1) begin
        checks++; failures++;
        $display("FAIL b2b_hold_mid: got %h expected %h", out1, E1);
      end
    end
    checks++; if (lat != 4) begin
      failures++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
    checks++; if (out1 !== E2) begin
      failures++; $display("FAIL b2b_result: got %h expected %h", out1, E2); end
    step();
  endtask

  task automatic test_cpc_variants();
    int lat;
    int exp_lat;
    logic [127:0] res;
    int ws[2];
    ws[0] = 2; ws[1] = 4;
    for (int k = 0; k < 2; k++) begin
      exp_lat = 4 / ws[k];
      run_op(ws[k], C1, 1'b0, lat, res);
      checks++; if (lat != exp_lat || res !== E1) begin
        failures++; $display("FAIL cpc%0d_round: got %h lat %0d expected %h lat %0d",
                             ws[k], res, lat, E1, exp_lat); end
      step();
      run_op(ws[k], C1, 1'b1, lat, res);
      checks++; if (lat != exp_lat || res !== E2) begin
        failures++; $display("FAIL cpc%0d_last: got %h lat %0d expected %h lat %0d",
                             ws[k], res, lat, E2, exp_lat); end
      step();
      run_op(ws[k], C3, 1'b0, lat, res);
      checks++; if (lat != exp_lat || res !== E3) begin
        failures++; $display("FAIL cpc%0d_invariant: got %h lat %0d expected %h lat %0d",
                             ws[k], res, lat, E3, exp_lat); end
      step();
      run_op(ws[k], 128'h0, 1'b0, lat, res);
      checks++; if (res !== 128'h0) begin
        failures++; $display("FAIL cpc%0d_zero: got %h expected 0", ws[k], res); end
      step();
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
    last_round = 1'b0; state_in = '0;
    test_reset();
    test_mix_round();
    test_last_round();
    test_invariant();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_cpc_variants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
